// File: rtl/uart_baud_gen_frac.sv
// Purpose : fractional baud-rate generator, 16x oversample tick (o_rx_tick) plus 1x bit tick (o_tx_tick).
// Latency : ticks are combinational from the period/oversample counters; a loaded divisor takes effect after the next rx tick.
// Backpr. : none - free-running timebase; i_en=0 or an active integer divisor of 0 stops and clears it.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   i_en                generator enable (low clears all counters)
//   i_div_int           integer part of the sample period, in clk cycles
//   i_div_frac          fractional part of the sample period, 1/2^DIV_FRAC_W cycle units
//   i_div_load          1-cycle pulse, capture i_div_int/i_div_frac into shadow registers
//   i_tx_sync           1-cycle pulse, restart the bit phase at a TX start of frame
//   o_rx_tick           oversample tick, 1 cycle wide
//   o_tx_tick           bit tick, always coincident with an o_rx_tick
//   o_div_err           active integer divisor is 0
//
// Optional feature macro: BAUD_FRAC_DIV_EN
//   defined   : fractional accumulator and carry built, reset divisor rounded to 1/2^DIV_FRAC_W
//   undefined : i_div_frac ignored, period is i_div_int only, reset divisor truncated

`default_nettype none

module uart_baud_gen_frac #(
   parameter int unsigned CFG_CLK_FREQ = 50000000,
   parameter int unsigned CFG_BAUDRATE = 115200,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned DIV_INT_W    = 16,
   parameter int unsigned DIV_FRAC_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic [DIV_INT_W-1:0]  i_div_int,
   input  logic [DIV_FRAC_W-1:0] i_div_frac,
   input  logic                  i_div_load,
   input  logic                  i_tx_sync,
   output logic                  o_rx_tick,
   output logic                  o_tx_tick,
   output logic                  o_div_err
);

   localparam int unsigned OS_W = $clog2(OVERSAMPLE);

   // Denominator of the reset divisor, computed 64 bits wide so CLK*2^F cannot overflow.
   localparam logic [63:0] DEN = 64'(CFG_BAUDRATE) * 64'(OVERSAMPLE);

`ifdef BAUD_FRAC_DIV_EN
   // round(CLK*2^F / DEN) == floor((2*CLK*2^F + DEN) / (2*DEN))
   localparam logic [63:0] DEF_FULL = ((64'(CFG_CLK_FREQ) << (DIV_FRAC_W + 1)) + DEN) / (DEN << 1);
   localparam logic [DIV_INT_W-1:0]  DEF_INT  = DIV_INT_W'(DEF_FULL >> DIV_FRAC_W);
   localparam logic [DIV_FRAC_W-1:0] DEF_FRAC = DIV_FRAC_W'(DEF_FULL);
`else
   localparam logic [63:0] DEF_FULL = 64'(CFG_CLK_FREQ) / DEN;
   localparam logic [DIV_INT_W-1:0]  DEF_INT  = DIV_INT_W'(DEF_FULL);
`endif

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [DIV_INT_W-1:0]  r_cnt;       // period counter, 0..P-1
   logic [OS_W-1:0]       r_os_cnt;    // oversample counter, 0..OVERSAMPLE-1
   logic [DIV_INT_W-1:0]  r_act_int;   // divisor in use
   logic [DIV_INT_W-1:0]  r_sh_int;    // divisor waiting for a period boundary
   logic                  r_pend;      // shadow holds a not-yet-applied load

`ifdef BAUD_FRAC_DIV_EN
   logic [DIV_FRAC_W-1:0] r_act_frac;
   logic [DIV_FRAC_W-1:0] r_sh_frac;
   logic [DIV_FRAC_W-1:0] r_acc;       // fractional phase accumulator
   logic                  r_carry;     // stretches the current period by one cycle
`else
   logic                  w_unused_frac;
   assign w_unused_frac = ^i_div_frac;
`endif

   // ---------------------------------------------------------------
   // Tick decode
   // ---------------------------------------------------------------
   logic                 w_div_zero;
   logic [DIV_INT_W:0]   w_period;
   logic [DIV_INT_W:0]   w_period_m1;
   logic                 w_last;
   logic                 w_rx_tick;
   logic                 w_os_last;
   logic                 w_tx_tick;
   logic                 w_clear;
   logic                 w_direct;
   logic                 w_activate;

   assign w_div_zero = (r_act_int == '0);

`ifdef BAUD_FRAC_DIV_EN
   assign w_period = {1'b0, r_act_int} + {{DIV_INT_W{1'b0}}, r_carry};
`else
   assign w_period = {1'b0, r_act_int};
`endif

   assign w_period_m1 = w_period - (DIV_INT_W + 1)'(1);
   assign w_last      = ({1'b0, r_cnt} == w_period_m1);

   // A tx_sync cycle never produces a tick: the frame restarts from a clean phase.
   assign w_rx_tick = i_en && !w_div_zero && !i_tx_sync && w_last;
   assign w_os_last = (r_os_cnt == OS_W'(OVERSAMPLE - 1));
   assign w_tx_tick = w_rx_tick && w_os_last;

   // Counters are parked at 0 whenever the generator cannot run or is being resynchronised.
   assign w_clear = !i_en || w_div_zero || i_tx_sync;

   // With the generator idle there is no period to protect, so a load goes straight in.
   assign w_direct = i_div_load && !i_en && !i_tx_sync;

   // Apply the shadow only on a period boundary (tick), or when nothing is counting.
   // A fresh load in the same cycle overwrites the shadow and waits for the next boundary.
   assign w_activate = r_pend && !i_div_load && !i_tx_sync && (w_rx_tick || !i_en || w_div_zero);

   // ---------------------------------------------------------------
   // Period / oversample counters and fractional accumulator
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_os_cnt <= '0;
`ifdef BAUD_FRAC_DIV_EN
         r_acc    <= '0;
         r_carry  <= 1'b0;
`endif
      end else if (w_clear) begin
         r_cnt    <= '0;
         r_os_cnt <= '0;
`ifdef BAUD_FRAC_DIV_EN
         r_acc    <= '0;
         r_carry  <= 1'b0;
`endif
      end else if (w_rx_tick) begin
         r_cnt    <= '0;
         r_os_cnt <= w_os_last ? '0 : r_os_cnt + OS_W'(1);
`ifdef BAUD_FRAC_DIV_EN
         // Carry-out of the fractional sum lengthens the following period by one cycle.
         {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, r_act_frac};
`endif
      end else begin
         r_cnt <= r_cnt + DIV_INT_W'(1);
      end
   end

   // ---------------------------------------------------------------
   // Divisor shadow / active registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_int  <= DEF_INT;
         r_sh_int   <= DEF_INT;
         r_pend     <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
         r_act_frac <= DEF_FRAC;
         r_sh_frac  <= DEF_FRAC;
`endif
      end else if (w_direct) begin
         r_act_int  <= i_div_int;
         r_sh_int   <= i_div_int;
         r_pend     <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
         r_act_frac <= i_div_frac;
         r_sh_frac  <= i_div_frac;
`endif
      end else if (i_div_load) begin
         r_sh_int   <= i_div_int;
         r_pend     <= 1'b1;
`ifdef BAUD_FRAC_DIV_EN
         r_sh_frac  <= i_div_frac;
`endif
      end else if (w_activate) begin
         r_act_int  <= r_sh_int;
         r_pend     <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
         r_act_frac <= r_sh_frac;
`endif
      end
   end

   assign o_rx_tick = w_rx_tick;
   assign o_tx_tick = w_tx_tick;
   assign o_div_err = w_div_zero;

endmodule

`default_nettype wire

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
Programmable fractional baud-rate generator for the APB-UART.
- Produces a 16x-oversample tick for the RX sampler and a 1x bit tick for the TX shifter.
- Divisor has an integer part and a fractional part; both are loaded at run time from the APB register block, with a reset default computed from parameters.
- Sits between the APB register file and the uart_tx/uart_rx cores.

Parameters:
- CFG_CLK_FREQ, 50000000: system clock frequency in Hz.
- CFG_BAUDRATE, 115200: baud rate used for the reset divisor.
- OVERSAMPLE, 16: rx_ticks per tx_tick, >=2.
- DIV_INT_W, 16: integer divisor width.
- DIV_FRAC_W, 4: fractional divisor width, in 1/2^DIV_FRAC_W clock units.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  generator enable.
- div_int  in  DIV_INT_W  integer part of sample period, in clk cycles.
- div_frac  in  DIV_FRAC_W  fractional part of sample period.
- div_load  in  1  1-cycle pulse: capture div_int/div_frac into shadow registers.
- tx_sync  in  1  1-cycle pulse: restart the bit phase (TX start of frame).
- rx_tick  out  1  oversample tick, 1 cycle wide.
- tx_tick  out  1  bit tick, 1 cycle wide, coincident with an rx_tick.
- div_err  out  1  active divisor has integer part 0.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state is in the clk domain.
- Reset default: DEF = round(CFG_CLK_FREQ*2^DIV_FRAC_W / (CFG_BAUDRATE*OVERSAMPLE)).
  - Active div_int = DEF>>DIV_FRAC_W; active div_frac = DEF low bits.
  - Defaults give 27 and 2 (27.125 cycles).
- Reset values: rx_tick=0, tx_tick=0, div_err=0, period counter=0, oversample counter=0, fractional accumulator=0, carry=0.
- Period counter:
  - Counts 0..P-1 while en=1, where P = active div_int + carry.
  - rx_tick=1 combinationally when the counter equals P-1 and en=1; the counter then wraps to 0.
- Fractional accumulator:
  - On each rx_tick: {carry_next, acc_next} = acc + active div_frac, computed DIV_FRAC_W+1 bits wide.
  - carry_next lengthens the next period by exactly 1 cycle.
  - Average period = div_int + div_frac/2^DIV_FRAC_W.
- Oversample counter:
  - Counts 0..OVERSAMPLE-1 on rx_tick.
  - tx_tick = rx_tick AND oversample counter == OVERSAMPLE-1; the counter then wraps to 0.
- Divisor update:
  - div_load captures the inputs into shadow registers and sets a pending flag.
  - Shadow values become active in the cycle after the next rx_tick; the current period always completes with the old divisor, so there are no runt ticks.
  - If en=0 when div_load arrives, the values become active on the next cycle.
  - A second div_load while pending overwrites the shadow values, last one wins.
  - A div_load coincident with rx_tick is applied after the following rx_tick.
- div_int==0 (active): div_err=1; period and oversample counters held at 0; no ticks.
- div_int==1 with div_frac==0: rx_tick asserted every cycle while en=1.
- en=0:
  - Period counter, oversample counter, accumulator and carry are cleared to 0; no ticks.
  - First rx_tick comes P cycles after en rises.
- tx_sync:
  - Clears the period counter, oversample counter, accumulator and carry in the next cycle.
  - Suppresses any tick in the cycle it is asserted.
  - Next tx_tick comes exactly OVERSAMPLE complete periods later.
  - tx_sync has priority over div_load activation in the same cycle; the load stays pending.
- Reset mid-operation: all state returns to reset values immediately; the pending load is discarded.

Optional Feature:
Macro BAUD_FRAC_DIV_EN.
- Defined: fractional accumulator and carry present; behaviour as above.
- Undefined:
  - div_frac is ignored and no accumulator or carry register is built; P = div_int always.
  - The reset default uses integer division truncation, giving 27 at defaults.

Test Plan:
- Reset release, en=1, defaults, with the macro defined -> first rx_tick at cycle 27 after en; 8 consecutive rx_tick intervals sum to 217 cycles, seven of 27 and one of 28; tx_tick on every 16th rx_tick.
- Same, with the macro undefined -> every rx_tick interval is 27 cycles; tx_tick interval 432 cycles.
- div_int=4, div_frac=0, div_load mid-period -> the current period finishes at the old length; all subsequent intervals are 4 cycles; tx_tick every 64 cycles.
- div_int=0 loaded -> div_err=1 after activation; no rx_tick/tx_tick for 1000 cycles; reload div_int=2 -> div_err=0, ticks every 2 cycles.
- tx_sync pulse at an arbitrary phase with div_int=10, div_frac=0 -> no tick in the sync cycle; next tx_tick exactly 160 cycles after the sync cycle.
- en toggled low for 5 cycles mid-bit, and separately rst_n pulsed during a pending load -> counters cleared; first rx_tick P cycles after en rises; after reset the divisor equals the default, not the shadow value.
